// File: rtl/evo_gate_array_pkg.sv
// Shared types and sizing helpers for the evolvable gate array.
// Optional build macro: EVO_LCELL_EN (see evo_gate_array.sv).
package evo_pkg;

  // Cell function codes, as carried in gene bits [2:0]
  typedef enum logic [2:0] {
    FN_AND    = 3'd0,
    FN_OR     = 3'd1,
    FN_XOR    = 3'd2,
    FN_NAND   = 3'd3,
    FN_NOR    = 3'd4,
    FN_XNOR   = 3'd5,
    FN_NOT_A  = 3'd6,
    FN_BUF_A  = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE
  } state_e;

  // Source fields are held zero-extended to a fixed width so the struct stays unparameterised
  localparam int SRC_MAX_W = 8;

  typedef struct packed {
    logic [SRC_MAX_W-1:0] src_b;
    logic [SRC_MAX_W-1:0] src_a;
    func_e                func;
  } gene_t;

  function automatic int sel_w(input int num_in, input int num_gates);
    return (num_in + num_gates <= 2) ? 1 : $clog2(num_in + num_gates);
  endfunction

  function automatic int gene_w(input int num_in, input int num_gates);
    return 3 + 2 * sel_w(num_in, num_gates);
  endfunction

endpackage

// File: rtl/evo_gate_array_if.sv
// Host-side configuration and evaluation bus of the evolvable gate array.
interface evo_gate_array_if #(
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 1,
  parameter int GENE_W  = 9
);
  logic               cfg_start;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [GENE_W-1:0]  cfg_data;
  logic               cfg_done;
  logic               eval_start;
  logic [NUM_IN-1:0]  eval_in;
  logic               eval_done;
  logic [NUM_OUT-1:0] eval_out;
  logic               busy;

  modport master (
    output cfg_start, cfg_valid, cfg_data, eval_start, eval_in,
    input  cfg_ready, cfg_done, eval_done, eval_out, busy
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, eval_start, eval_in,
    output cfg_ready, cfg_done, eval_done, eval_out, busy
  );
endinterface

// File: rtl/evo_gate_array_gate.sv
// One configurable 2-input cell of the evolvable gate array.
module evo_gate
  import evo_pkg::*;
(
  input  func_e func,
  input  logic  a,
  input  logic  b,
  output logic  y
);

  // Evaluate the selected boolean function
  always_comb begin
    y = 1'b0;
    case (func)
      FN_AND:   y = a & b;
      FN_OR:    y = a | b;
      FN_XOR:   y = a ^ b;
      FN_NAND:  y = ~(a & b);
      FN_NOR:   y = ~(a | b);
      FN_XNOR:  y = ~(a ^ b);
      FN_NOT_A: y = ~a;
      FN_BUF_A: y = a;
      default:  y = 1'b0;
    endcase
  end

endmodule

// File: rtl/evo_gate_array.sv
// Evolvable gate network: runtime-loaded genome, any-to-any routing incl. feedback,
// and an apply/settle/capture evaluation handshake.
// Build macro EVO_LCELL_EN: cells become combinational behind LCELL buffers and the
// captured outputs pass a 2-flop synchroniser (eval latency grows by 2 clocks).
module evo_gate_array
  import evo_pkg::*;
#(
  parameter int NUM_IN        = 2,
  parameter int NUM_GATES     = 6,
  parameter int NUM_OUT       = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  evo_gate_array_if.slave bus
);

  localparam int SEL_W     = sel_w(NUM_IN, NUM_GATES);
  localparam int GENE_W    = gene_w(NUM_IN, NUM_GATES);
  localparam int NUM_SRC   = NUM_IN + NUM_GATES;
  localparam int NUM_WORDS = NUM_GATES + NUM_OUT;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int STL_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     word_cnt;
  logic [STL_W-1:0]     settle_cnt;
  logic [NUM_IN-1:0]    in_q;
  gene_t                genes   [NUM_GATES];
  logic [SRC_MAX_W-1:0] out_sel [NUM_OUT];
  logic [NUM_GATES-1:0] cell_y, cell_q;
  logic [NUM_SRC-1:0]   src_vec;
  logic [NUM_OUT-1:0]   out_vec;
  logic                 accept, last_word, eval_go, settle_end;

  // Routing mux: codes past the last cell read constant 0
  function automatic logic pick(input logic [SRC_MAX_W-1:0] s, input logic [NUM_SRC-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (s == SRC_MAX_W'(i)) r = v[i];
    return r;
  endfunction

  function automatic gene_t decode_gene(input logic [GENE_W-1:0] d);
    gene_t g;
    g       = '0;
    g.func  = func_e'(d[2:0]);
    g.src_a = SRC_MAX_W'(d[3 +: SEL_W]);
    g.src_b = SRC_MAX_W'(d[3+SEL_W +: SEL_W]);
    return g;
  endfunction

  assign src_vec    = {cell_q, in_q};
  assign accept     = bus.cfg_valid && (state_q == ST_LOAD);
  assign last_word  = (word_cnt == CNT_W'(NUM_WORDS - 1));
  assign eval_go    = (state_q == ST_IDLE) && bus.eval_start && !bus.cfg_start;
  assign settle_end = (settle_cnt == STL_W'(SETTLE_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; cfg_start wins over a simultaneous eval_start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.cfg_start) state_d = ST_LOAD;
                  else if (bus.eval_start) state_d = ST_SETTLE;
      ST_LOAD:    if (accept && last_word) state_d = ST_IDLE;
      ST_SETTLE:  if (settle_end) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.cfg_ready = (state_q == ST_LOAD);
    bus.busy      = (state_q != ST_IDLE);
  end

  // Load word counter, settle counter, input vector register, load-complete pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt     <= '0;
      settle_cnt   <= '0;
      in_q         <= '0;
      bus.cfg_done <= 1'b0;
    end else begin
      bus.cfg_done <= accept && last_word;
      if (state_q != ST_LOAD) word_cnt <= '0;
      else if (accept)        word_cnt <= word_cnt + 1'b1;
      if (state_q != ST_SETTLE) settle_cnt <= '0;
      else                      settle_cnt <= settle_cnt + 1'b1;
      if (eval_go) in_q <= bus.eval_in;
    end
  end

  // Genome store: cell genes first, then output selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GATES; i++) genes[i]   <= '0;
      for (int o = 0; o < NUM_OUT; o++)   out_sel[o] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_GATES; i++)
        if (word_cnt == CNT_W'(i)) genes[i] <= decode_gene(bus.cfg_data);
      for (int o = 0; o < NUM_OUT; o++)
        if (word_cnt == CNT_W'(NUM_GATES + o)) out_sel[o] <= SRC_MAX_W'(bus.cfg_data[SEL_W-1:0]);
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_cell
    logic a_s, b_s;
    assign a_s = pick(genes[g].src_a, src_vec);
    assign b_s = pick(genes[g].src_b, src_vec);

    evo_gate u_gate (
      .func (genes[g].func),
      .a    (a_s),
      .b    (b_s),
      .y    (cell_y[g])
    );

`ifdef EVO_LCELL_EN
    LCELL u_lcell (.in(cell_y[g]), .out(cell_q[g]));
`else
    logic q;
    // Cell state flop, updated every clock so feedback genomes behave as sequential logic
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= cell_y[g];
    end
    assign cell_q[g] = q;
`endif
  end

  // Output routing muxes
  always_comb begin
    out_vec = '0;
    for (int o = 0; o < NUM_OUT; o++) out_vec[o] = pick(out_sel[o], src_vec);
  end

`ifdef EVO_LCELL_EN
  logic [NUM_OUT-1:0] sync_p1, sync_p2;
  logic               vld_p1, vld_p2;

  // Synchronise asynchronous cell outputs and delay the capture strobe to match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p1       <= '0;
      sync_p2       <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      bus.eval_done <= 1'b0;
      bus.eval_out  <= '0;
    end else begin
      sync_p1       <= out_vec;
      sync_p2       <= sync_p1;
      vld_p1        <= (state_q == ST_CAPTURE);
      vld_p2        <= vld_p1;
      bus.eval_done <= vld_p2;
      if (vld_p2) bus.eval_out <= sync_p2;
    end
  end
`else
  // Capture routed outputs and pulse eval_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eval_done <= 1'b0;
      bus.eval_out  <= '0;
    end else begin
      bus.eval_done <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) bus.eval_out <= out_vec;
    end
  end
`endif

endmodule

// File: tb/tb_evo_gate_array.sv
// Self-checking bench for evo_gate_array (default parameters, 9-bit genes).
module tb_evo_gate_array;
  import evo_pkg::*;

`ifdef EVO_LCELL_EN
  localparam int EXP_LAT = 7;
`else
  localparam int EXP_LAT = 5;
`endif

  logic clk;
  logic rst_n;

  evo_gate_array_if #(.NUM_IN(2), .NUM_OUT(1), .GENE_W(9)) ifc ();

  evo_gate_array #(
    .NUM_IN(2), .NUM_GATES(6), .NUM_OUT(1), .SETTLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:0] exp_q [$];
  logic [8:0] gw [0:6];
  int         n_acc, n_done, done_cyc;
  bit         done_order_ok;

  function automatic logic [8:0] mk_gene(input int f, input int a, input int b);
    logic [2:0] fv, av, bv;
    fv = f[2:0];
    av = a[2:0];
    bv = b[2:0];
    return {bv, av, fv};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_genome();
    for (int i = 0; i < 7; i++) gw[i] = '0;
  endtask

  // Drives a full genome load of gw[]; records accepts, done pulses and when done arrived
  task automatic do_load(input bit toggle);
    int k, cyc;
    k = 0; cyc = 0; n_acc = 0; n_done = 0; done_cyc = -1; done_order_ok = 1;
    ifc.cfg_start = 1'b1;
    @(negedge clk);
    ifc.cfg_start = 1'b0;
    while (n_done == 0 && cyc < 60) begin
      ifc.cfg_valid = (k < 7) && (!toggle || (cyc % 2 == 0));
      ifc.cfg_data  = gw[(k < 7) ? k : 6];
      if (ifc.cfg_valid && ifc.cfg_ready) begin
        n_acc++;
        k++;
      end
      @(negedge clk);
      if (ifc.cfg_done) begin
        n_done++;
        done_cyc = cyc;
        if (n_acc != 7) done_order_ok = 0;
      end
      cyc++;
    end
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic run_eval(input logic [1:0] vin, output logic [0:0] vout, output int lat);
    ifc.eval_in    = vin;
    ifc.eval_start = 1'b1;
    @(negedge clk);
    ifc.eval_start = 1'b0;
    lat = 0;
    while (!ifc.eval_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    vout = ifc.eval_out;
  endtask

  task automatic test_reset();
    logic [0:0] v, e;
    int lat;
    apply_reset();
    n_checks++; if (ifc.eval_out !== 1'b0) $display("FAIL reset_eval_out got %b want 0", ifc.eval_out); else n_pass++;
    n_checks++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ifc.busy); else n_pass++;
    n_checks++; if (ifc.cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got %b want 0", ifc.cfg_ready); else n_pass++;
    n_checks++; if (ifc.eval_done !== 1'b0 || ifc.cfg_done !== 1'b0)
      $display("FAIL reset_done_pulses got %b%b want 00", ifc.eval_done, ifc.cfg_done); else n_pass++;
    exp_q.push_back(1'b1);
    run_eval(2'b11, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL reset_eval_11 got %b want %b", v, e); else n_pass++;
    n_checks++; if (lat !== EXP_LAT) $display("FAIL reset_latency got %0d want %0d", lat, EXP_LAT); else n_pass++;
    exp_q.push_back(1'b0);
    run_eval(2'b10, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL reset_eval_10 got %b want %b", v, e); else n_pass++;
  endtask

  task automatic test_inverter();
    logic [0:0] v, e;
    int lat;
    clear_genome();
    gw[0] = mk_gene(4, 0, 0);
    gw[6] = 9'd2;
    do_load(1'b0);
    n_checks++; if (n_acc !== 7 || n_done !== 1)
      $display("FAIL inv_load got accepts=%0d done=%0d want 7/1", n_acc, n_done); else n_pass++;
    n_checks++; if (ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b0)
      $display("FAIL inv_idle_after_load got busy=%b ready=%b want 0/0", ifc.busy, ifc.cfg_ready); else n_pass++;
    exp_q.push_back(1'b0);
    run_eval(2'b01, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL inv_eval_01 got %b want %b", v, e); else n_pass++;
    n_checks++; if (lat !== EXP_LAT) $display("FAIL inv_latency got %0d want %0d", lat, EXP_LAT); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifc.eval_done !== 1'b0) $display("FAIL inv_done_width got %b want 0", ifc.eval_done); else n_pass++;
    exp_q.push_back(1'b1);
    run_eval(2'b00, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL inv_eval_00 got %b want %b", v, e); else n_pass++;
  endtask

  task automatic test_latch();
    logic [0:0] v, e;
    int lat;
    apply_reset();
    clear_genome();
    gw[0] = mk_gene(1, 1, 2);
    gw[6] = 9'd2;
    do_load(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    run_eval(2'b00, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL latch_initial got %b want %b", v, e); else n_pass++;
    run_eval(2'b10, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL latch_set got %b want %b", v, e); else n_pass++;
    run_eval(2'b00, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL latch_hold got %b want %b", v, e); else n_pass++;
    apply_reset();
    n_checks++; if (ifc.eval_out !== 1'b0) $display("FAIL latch_reset got %b want 0", ifc.eval_out); else n_pass++;
  endtask

  task automatic test_handshake();
    logic [0:0] v, e;
    int lat, extra_done, bad_ready;
    clear_genome();
    gw[5] = mk_gene(7, 1, 0);
    gw[6] = 9'd7;
    do_load(1'b1);
    n_checks++; if (n_acc !== 7) $display("FAIL hs_accepts got %0d want 7", n_acc); else n_pass++;
    n_checks++; if (n_done !== 1 || !done_order_ok)
      $display("FAIL hs_done got count=%0d order_ok=%0d want 1/1", n_done, done_order_ok); else n_pass++;
    n_checks++; if (done_cyc !== 12) $display("FAIL hs_done_cycle got %0d want 12", done_cyc); else n_pass++;
    extra_done = 0; bad_ready = 0;
    for (int c = 0; c < 4; c++) begin
      ifc.cfg_valid = 1'b1;
      ifc.cfg_data  = 9'h1FF;
      if (ifc.cfg_ready !== 1'b0) bad_ready++;
      @(negedge clk);
      if (ifc.cfg_done) extra_done++;
    end
    ifc.cfg_valid = 1'b0;
    n_checks++; if (extra_done !== 0 || bad_ready !== 0)
      $display("FAIL hs_valid_outside_load got done=%0d ready_high=%0d want 0/0", extra_done, bad_ready); else n_pass++;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    run_eval(2'b10, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL sel7_eval_10 got %b want %b", v, e); else n_pass++;
    run_eval(2'b00, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL sel7_eval_00 got %b want %b", v, e); else n_pass++;
  endtask

  task automatic test_conflicts();
    logic [0:0] got, e;
    int n_ed;
    ifc.eval_in    = 2'b11;
    ifc.cfg_start  = 1'b1;
    ifc.eval_start = 1'b1;
    @(negedge clk);
    ifc.cfg_start  = 1'b0;
    ifc.eval_start = 1'b0;
    n_checks++; if (ifc.cfg_ready !== 1'b1) $display("FAIL conflict_load_wins got ready=%b want 1", ifc.cfg_ready); else n_pass++;
    n_ed = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.eval_done) n_ed++;
    end
    n_checks++; if (n_ed !== 0) $display("FAIL conflict_no_eval got %0d want 0", n_ed); else n_pass++;
    clear_genome();
    gw[0] = mk_gene(7, 0, 0);
    gw[6] = 9'd2;
    do_load(1'b0);
    n_checks++; if (n_acc !== 7 || n_done !== 1)
      $display("FAIL conflict_load got accepts=%0d done=%0d want 7/1", n_acc, n_done); else n_pass++;
    ifc.eval_in    = 2'b01;
    ifc.eval_start = 1'b1;
    exp_q.push_back(1'b1);
    @(negedge clk);
    ifc.eval_start = 1'b0;
    n_ed = 0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        ifc.eval_in    = 2'b00;
        ifc.eval_start = 1'b1;
      end else begin
        ifc.eval_start = 1'b0;
      end
      @(negedge clk);
      if (ifc.eval_done) begin
        n_ed++;
        got = ifc.eval_out;
      end
    end
    ifc.eval_start = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (n_ed !== 1) $display("FAIL busy_eval_ignored got %0d done pulses want 1", n_ed); else n_pass++;
    n_checks++; if (got !== e) $display("FAIL busy_eval_value got %b want %b", got, e); else n_pass++;
  endtask

  task automatic test_abort();
    logic [0:0] v, e;
    int lat;
    clear_genome();
    gw[0] = mk_gene(4, 0, 0);
    gw[6] = 9'd2;
    do_load(1'b0);
    ifc.cfg_start = 1'b1;
    @(negedge clk);
    ifc.cfg_start = 1'b0;
    ifc.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.cfg_data = mk_gene(6, 1, 0);
      @(negedge clk);
    end
    ifc.cfg_valid = 1'b0;
    n_checks++; if (ifc.busy !== 1'b1) $display("FAIL abort_mid_load got busy=%b want 1", ifc.busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b0)
      $display("FAIL abort_async got busy=%b ready=%b want 0/0", ifc.busy, ifc.cfg_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ifc.eval_out !== 1'b0) $display("FAIL abort_eval_out got %b want 0", ifc.eval_out); else n_pass++;
    exp_q.push_back(1'b1);
    run_eval(2'b01, v, lat);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL abort_genome_reset got %b want %b", v, e); else n_pass++;
    n_checks++; if (lat !== EXP_LAT) $display("FAIL abort_latency got %0d want %0d", lat, EXP_LAT); else n_pass++;
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.cfg_start  = 1'b0;
    ifc.cfg_valid  = 1'b0;
    ifc.cfg_data   = '0;
    ifc.eval_start = 1'b0;
    ifc.eval_in    = '0;
    @(negedge clk);
    test_reset();
    test_inverter();
    test_latch();
    test_handshake();
    test_conflicts();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
